bcd_entry_register: RTL
=======================

Name: bcd_entry_register

Overview:
Parametrised successor to the keypad digit register. It collects decimal key codes into an N-digit BCD entry buffer and supports backspace, an enter/lock key and clear. A multi-cycle iterative converter produces a saturated binary operand. It sits between the keyboard scan-code decoder and the ALU operand/display path.

Parameters:
NUM_DIGITS, 3, number of BCD digits held (1..6)
MAX_VALUE, 255, saturation limit of the binary output
BIN_W, $clog2(MAX_VALUE+1), binary output width (derived, do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
op_ctrl  in  1  clear entry, return to ENTRY; highest priority
key_val  in  4  decoded key: 0-9 digit, 4'hE backspace, 4'hF enter, 4'hA-4'hD ignored
key_valid  in  1  one-cycle strobe qualifying key_val
bcd_value  out  4*NUM_DIGITS  raw entered digits, LSD in [3:0], unsaturated
bin_value  out  BIN_W  converted value, clamped to MAX_VALUE
saturated  out  1  last completed conversion exceeded MAX_VALUE
digit_count  out  $clog2(NUM_DIGITS+1)  digits currently held
full  out  1  digit_count == NUM_DIGITS
conv_busy  out  1  conversion in progress
locked  out  1  FSM in LOCKED state
value_ready  out  1  one-cycle pulse: locked and conversion complete

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM in ENTRY, converter idle.
- Entry FSM has two states, ENTRY and LOCKED.
- ENTRY, key_valid=1, action by key:
  - Digit with !full: shift left 4, insert digit at LSD, count+1, start conversion.
  - Digit 0 with count==0: ignored (no leading zeros).
  - Digit with full: ignored; digits and count unchanged.
  - 4'hE with count>0: shift right 4, count-1, start conversion. With count==0: ignored.
  - 4'hF: go to LOCKED; digits are kept.
  - 4'hA-4'hD: ignored.
- LOCKED: all keys ignored. op_ctrl returns the FSM to ENTRY.
- op_ctrl=1, in any state, with or without a simultaneous key: next edge clears digits and count, sets bin_value=0 and saturated=0, aborts conversion, FSM goes to ENTRY.
- Converter:
  - Started at the edge that updates the digits. conv_busy is high from that edge for NUM_DIGITS cycles.
  - Each cycle processes one digit, MSD to LSD: acc = acc*10 + digit.
  - acc is 4*NUM_DIGITS bits wide and never overflows.
  - At the final edge: bin_value = min(acc, MAX_VALUE), saturated = (acc > MAX_VALUE), conv_busy drops.
  - bin_value and saturated hold their previous values while busy.
- Edit while busy: the conversion restarts from the MSD using the new digits. Full NUM_DIGITS latency is counted from the restart.
- Enter while busy: FSM locks immediately. value_ready pulses on the cycle after conversion completes.
- Enter while idle: value_ready pulses on the cycle after entering LOCKED.
- value_ready pulses exactly once per LOCKED episode.
- Enter with count==0: lock with value 0, then pulse value_ready.
- Reset mid-conversion: immediate return to reset values; no pulse.

Decomposition:
- Package bcd_entry_pkg holds:
  - KEY_BACKSPACE = 4'hE, KEY_ENTER = 4'hF
  - entry_state_t enum {ENTRY, LOCKED}
  - function is_digit(key)
- Sub-module bcd_to_bin_seq (parameters NUM_DIGITS, MAX_VALUE) contains the iterative converter.
  - Inputs: start, abort, digits.
  - Outputs: busy, bin_value, saturated.
- The top level holds the digit shift register, count, FSM and value_ready generation.

Test Plan:
- Defaults; keys 1,2,3 spaced 5 cycles -> bcd_value=12'h123, digit_count=3, full=1; 3 cycles after the last key bin_value=123, saturated=0.
- Keys 3,0,0 -> bcd_value=12'h300, bin_value=255, saturated=1; then 4'hE -> bcd_value=12'h030, bin_value=30, saturated=0.
- Keys 0,0,7,8,9,5 -> leading zeros ignored, bcd_value=12'h789, 5 ignored; 4'hE four times -> count 0, bin_value=0, extra backspace ignored.
- Keys 4,2 back-to-back, then 4'hF on the next cycle -> locked=1 immediately; single value_ready pulse after conversion with bin_value=42; later key 9 ignored.
- op_ctrl and key 5 in the same cycle while LOCKED with value 42 -> next cycle all cleared, FSM ENTRY, digit 5 not stored.
- Key 2 then rst=0 one cycle later (mid-conversion) -> all outputs 0 at once; no value_ready after rst release.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// Shared key codes, entry FSM state type and key classification helper
// for the BCD entry register.
package bcd_entry_pkg;

  localparam logic [3:0] KEY_BACKSPACE = 4'hE;
  localparam logic [3:0] KEY_ENTER     = 4'hF;

  typedef enum logic {
    ENTRY  = 1'b0,
    LOCKED = 1'b1
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter: one digit per cycle, MSD first,
// result clamped to MAX_VALUE with a saturation flag.
module bcd_to_bin_seq
  import bcd_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned MAX_VALUE  = 255,
  localparam int unsigned BIN_W     = $clog2(MAX_VALUE + 1),
  localparam int unsigned ACC_W     = 4 * NUM_DIGITS,
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [ACC_W-1:0] digits_i,
  output logic             busy_o,
  output logic [BIN_W-1:0] bin_value_o,
  output logic             saturated_o
);

  logic             busy_q;
  logic [ACC_W-1:0] acc_q;
  logic [IDX_W-1:0] idx_q;
  logic [BIN_W-1:0] bin_q;
  logic             sat_q;

  logic [3:0]       cur_digit_c;
  logic [ACC_W-1:0] acc_next_c;
  logic             sat_c;

  // Digit selected by idx_q; the digit register is stable while busy.
  always_comb begin
    cur_digit_c = 4'(digits_i >> {idx_q, 2'b00});
    acc_next_c  = (acc_q * ACC_W'(10)) + ACC_W'(cur_digit_c);
    sat_c       = 32'(acc_next_c) > 32'(MAX_VALUE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      acc_q  <= '0;
      idx_q  <= '0;
      bin_q  <= '0;
      sat_q  <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      acc_q  <= '0;
      idx_q  <= '0;
      bin_q  <= '0;
      sat_q  <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      acc_q  <= '0;
      idx_q  <= IDX_W'(NUM_DIGITS - 1);
    end else if (busy_q) begin
      if (idx_q == '0) begin
        busy_q <= 1'b0;
        bin_q  <= sat_c ? BIN_W'(MAX_VALUE) : BIN_W'(acc_next_c);
        sat_q  <= sat_c;
      end else begin
        acc_q <= acc_next_c;
        idx_q <= idx_q - IDX_W'(1);
      end
    end
  end

  assign busy_o      = busy_q;
  assign bin_value_o = bin_q;
  assign saturated_o = sat_q;

endmodule

// File: rtl/bcd_entry_register.sv
// Keypad entry buffer: collects decimal keys into an N-digit BCD register
// with backspace/enter/clear, and hands the digits to the binary converter.
module bcd_entry_register
  import bcd_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned MAX_VALUE  = 255,
  localparam int unsigned BIN_W     = $clog2(MAX_VALUE + 1),
  localparam int unsigned DIG_W     = 4 * NUM_DIGITS,
  localparam int unsigned CNT_W     = $clog2(NUM_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_ctrl,
  input  logic [3:0]       key_val,
  input  logic             key_valid,
  output logic [DIG_W-1:0] bcd_value,
  output logic [BIN_W-1:0] bin_value,
  output logic             saturated,
  output logic [CNT_W-1:0] digit_count,
  output logic             full,
  output logic             conv_busy,
  output logic             locked,
  output logic             value_ready
);

  entry_state_t     state_q, state_d;
  logic [DIG_W-1:0] digits_q, digits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             start_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ENTRY;
      digits_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(NUM_DIGITS));
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    done_d   = done_q;
    ready_d  = 1'b0;
    start_c  = 1'b0;

    if (op_ctrl) begin
      state_d  = ENTRY;
      digits_d = '0;
      count_d  = '0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ENTRY: begin
          done_d = 1'b0;
          if (key_valid) begin
            if (is_digit(key_val)) begin
              // Leading zeros are dropped so the count reflects significant digits.
              if ((count_q != CNT_W'(NUM_DIGITS)) &&
                  !((key_val == 4'd0) && (count_q == '0))) begin
                digits_d = DIG_W'({digits_q, key_val});
                count_d  = count_q + CNT_W'(1);
                start_c  = 1'b1;
              end
            end else if (key_val == KEY_BACKSPACE) begin
              if (count_q != '0) begin
                digits_d = digits_q >> 4;
                count_d  = count_q - CNT_W'(1);
                start_c  = 1'b1;
              end
            end else if (key_val == KEY_ENTER) begin
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          // One ready pulse per lock, once the converter has settled.
          if (!conv_busy && !done_q) begin
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end
        default: state_d = ENTRY;
      endcase
    end
  end

  bcd_to_bin_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .MAX_VALUE  (MAX_VALUE)
  ) u_conv (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_c),
    .abort_i     (op_ctrl),
    .digits_i    (digits_q),
    .busy_o      (conv_busy),
    .bin_value_o (bin_value),
    .saturated_o (saturated)
  );

  assign bcd_value   = digits_q;
  assign digit_count = count_q;
  assign full        = full_q;
  assign locked      = (state_q == LOCKED);
  assign value_ready = ready_q;

endmodule
